// File: rtl/note_track_engine.sv
// Note-highway engine: stores a song of LANES-bit columns, scores key presses at the
// strike slot and redraws the visible window as a one-pixel-per-cycle plot stream.
module note_track_engine #(
  parameter int         LANES    = 3,
  parameter int         SONG_LEN = 128,
  parameter int         VIS      = 4,
  parameter int         BOX_W    = 30,
  parameter int         BOX_H    = 60,
  parameter int         X0       = 0,
  parameter int         Y0       = 60,
  parameter logic [2:0] NOTE_COL = 3'b101,
  parameter logic [2:0] BG_COL   = 3'b000,
  parameter int         SCORE_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               col_valid,
  input  logic [LANES-1:0]   col_data,
  output logic               col_ready,
  input  logic               start,
  input  logic               step,
  input  logic [LANES-1:0]   note_in,
  output logic               plot_valid,
  input  logic               plot_ready,
  output logic [8:0]         plot_x,
  output logic [7:0]         plot_y,
  output logic [2:0]         plot_colour,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak,
  output logic [SCORE_W-1:0] best_streak,
  output logic               overrun,
  output logic               song_done
);

  localparam int LEN_W  = $clog2(SONG_LEN + 1);
  localparam int ADR_W  = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SLOT_W = (VIS > 1) ? $clog2(VIS) : 1;
  localparam int PX_W   = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int PY_W   = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE, DRAW, PLAY, DONE} state_t;
  state_t state, stateNext;

  logic [LANES-1:0]   songMem [SONG_LEN];
  logic [LEN_W-1:0]   length, pos;
  logic [LANE_W-1:0]  lane;
  logic [SLOT_W-1:0]  slot;
  logic [PY_W-1:0]    py;
  logic [PX_W-1:0]    px;
  logic               stepPending;

  logic               accept, lastPixel, playStep, noteBit;
  logic [LEN_W:0]     winIdx;
  logic [LANES-1:0]   curCol, missBits;
  int                 hitCnt, xPix, yPix;
  logic [SCORE_W-1:0] streakNew;

  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a, input int b);
    int sum;
    sum = int'(a) + b;
    if (sum > int'(SCORE_MAX)) return SCORE_MAX;
    return SCORE_W'(sum);
  endfunction

  function automatic int popCount(input logic [LANES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++) n += int'(v[i]);
    return n;
  endfunction

  assign col_ready = (state == IDLE) && (length < LEN_W'(SONG_LEN));
  assign song_done = (state == DONE);
  assign accept    = plot_valid && plot_ready;
  assign lastPixel = (px == PX_W'(BOX_W - 1)) && (py == PY_W'(BOX_H - 1)) &&
                     (slot == '0) && (lane == LANE_W'(LANES - 1));
  assign playStep  = (state == PLAY) && (step || stepPending);

  // Window read: columns past the loaded length show as empty boxes
  always_comb begin
    winIdx  = {1'b0, pos} + (LEN_W + 1)'(slot);
    noteBit = 1'b0;
    if (winIdx < {1'b0, length}) noteBit = songMem[winIdx[ADR_W-1:0]][lane];
    xPix = X0 + (VIS - 1 - int'(slot)) * BOX_W + int'(px);
    yPix = Y0 + int'(lane) * BOX_H + int'(py);
    plot_x      = plot_valid ? 9'(xPix) : '0;
    plot_y      = plot_valid ? 8'(yPix) : '0;
    plot_colour = plot_valid ? (noteBit ? NOTE_COL : BG_COL) : '0;
  end

  always_comb begin
    curCol = '0;
    if (pos < length) curCol = songMem[pos[ADR_W-1:0]];
    missBits  = curCol & ~note_in;
    hitCnt    = popCount(curCol & note_in);
    streakNew = (|missBits) ? '0 : satAdd(streak, hitCnt);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (start) stateNext = (length == '0) ? DONE : DRAW;
      DRAW:       if (accept && lastPixel) stateNext = (pos == length) ? DONE : PLAY;
      PLAY:       if (step || stepPending) stateNext = DRAW;
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && col_valid && col_ready && !start)
      songMem[length[ADR_W-1:0]] <= col_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      length      <= '0;
      pos         <= '0;
      lane        <= '0;
      slot        <= SLOT_W'(VIS - 1);
      py          <= '0;
      px          <= '0;
      plot_valid  <= 1'b0;
      stepPending <= 1'b0;
      score       <= '0;
      streak      <= '0;
      best_streak <= '0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pos         <= '0;
            score       <= '0;
            streak      <= '0;
            best_streak <= '0;
            overrun     <= 1'b0;
            stepPending <= 1'b0;
          end else if (state == IDLE && col_valid && col_ready) begin
            length <= length + 1'b1;
          end
        end
        DRAW: begin
          plot_valid <= !(accept && lastPixel);
          // Box scan: px fastest, then py, then slot (descending), then lane
          if (accept) begin
            if (px == PX_W'(BOX_W - 1)) begin
              px <= '0;
              if (py == PY_W'(BOX_H - 1)) begin
                py <= '0;
                if (slot == '0) begin
                  slot <= SLOT_W'(VIS - 1);
                  lane <= (lane == LANE_W'(LANES - 1)) ? '0 : lane + 1'b1;
                end else begin
                  slot <= slot - 1'b1;
                end
              end else begin
                py <= py + 1'b1;
              end
            end else begin
              px <= px + 1'b1;
            end
          end
          if (step) begin
            if (stepPending) overrun <= 1'b1;
            else             stepPending <= 1'b1;
          end
          if (accept && lastPixel && pos == length) stepPending <= 1'b0;
        end
        PLAY: begin
          if (playStep) begin
            score       <= satAdd(score, hitCnt);
            streak      <= streakNew;
            best_streak <= (streakNew > best_streak) ? streakNew : best_streak;
            pos         <= pos + 1'b1;
            stepPending <= 1'b0;
            if (step && stepPending) overrun <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_track_engine.sv
// Randomized bench for note_track_engine: a song/score model predicts every pixel of each
// redraw and the score registers for an 8-bit and a 2-bit (saturating) instance.
module tb_note_track_engine;
  localparam int LANES = 3, SONG_LEN = 4, VIS = 4, BOX_W = 2, BOX_H = 2, X0 = 0, Y0 = 60;

  logic       clock = 1'b0, reset = 1'b1, col_valid = 1'b0, start = 1'b0, step = 1'b0;
  logic       plot_ready = 1'b1;
  logic [2:0] col_data = '0, note_in = '0;

  logic       col_ready, plot_valid, overrun, song_done;
  logic [8:0] plot_x;
  logic [7:0] plot_y;
  logic [2:0] plot_colour;
  logic [7:0] score, streak, best_streak;

  logic       sColReady, sPlotValid, sOverrun, sSongDone;
  logic [8:0] sPlotX;
  logic [7:0] sPlotY;
  logic [2:0] sPlotColour;
  logic [1:0] sScore, sStreak, sBest;

  note_track_engine #(.LANES(LANES), .SONG_LEN(SONG_LEN), .VIS(VIS), .BOX_W(BOX_W),
    .BOX_H(BOX_H), .X0(X0), .Y0(Y0), .SCORE_W(8)) dut (
    .clock(clock), .reset(reset), .col_valid(col_valid), .col_data(col_data),
    .col_ready(col_ready), .start(start), .step(step), .note_in(note_in),
    .plot_valid(plot_valid), .plot_ready(plot_ready), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .score(score), .streak(streak), .best_streak(best_streak),
    .overrun(overrun), .song_done(song_done));

  note_track_engine #(.LANES(LANES), .SONG_LEN(SONG_LEN), .VIS(VIS), .BOX_W(BOX_W),
    .BOX_H(BOX_H), .X0(X0), .Y0(Y0), .SCORE_W(2)) dutSat (
    .clock(clock), .reset(reset), .col_valid(col_valid), .col_data(col_data),
    .col_ready(sColReady), .start(start), .step(step), .note_in(note_in),
    .plot_valid(sPlotValid), .plot_ready(plot_ready), .plot_x(sPlotX), .plot_y(sPlotY),
    .plot_colour(sPlotColour), .score(sScore), .streak(sStreak), .best_streak(sBest),
    .overrun(sOverrun), .song_done(sSongDone));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int song [SONG_LEN];
  int songLen = 0, mPos = 0, mScore = 0, mRun = 0, mBestRun = 0, mOver = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int satv(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkScores(input string tag);
    checkVal({tag, "_score"}, 32'(score), satv(mScore, 8));
    checkVal({tag, "_streak"}, 32'(streak), satv(mRun, 8));
    checkVal({tag, "_best"}, 32'(best_streak), satv(mBestRun, 8));
    checkVal({tag, "_overrun"}, 32'(overrun), mOver);
    checkVal({tag, "_sat_score"}, 32'(sScore), satv(mScore, 2));
    checkVal({tag, "_sat_streak"}, 32'(sStreak), satv(mRun, 2));
    checkVal({tag, "_sat_best"}, 32'(sBest), satv(mBestRun, 2));
  endtask

  task automatic checkCleared(input string tag);
    checkVal({tag, "_plot"}, 32'({plot_valid, plot_x, plot_y, plot_colour}), 0);
    checkVal({tag, "_stat"}, 32'({score, streak, best_streak, overrun, song_done}), 0);
    checkVal({tag, "_ready"}, 32'(col_ready), 1);
    checkVal({tag, "_sat"}, 32'({sPlotValid, sScore, sStreak, sBest, sOverrun, sSongDone}), 0);
  endtask

  task automatic doReset();
    reset = 1'b1; col_valid = 1'b0; start = 1'b0; step = 1'b0; plot_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    songLen = 0; mPos = 0; mScore = 0; mRun = 0; mBestRun = 0; mOver = 0;
  endtask

  task automatic loadCols(input int n);
    for (int i = 0; i < n; i++) begin
      col_valid = 1'b1;
      col_data  = 3'(song[i]);
      tick();
      songLen++;
    end
    col_valid = 1'b0;
  endtask

  task automatic doStart(input bit withCol);
    start = 1'b1;
    col_valid = withCol;
    col_data  = 3'b111;
    tick();
    start = 1'b0;
    col_valid = 1'b0;
    mPos = 0; mScore = 0; mRun = 0; mBestRun = 0; mOver = 0;
  endtask

  task automatic modelStep(input int keys);
    int col, hits;
    col  = song[mPos];
    hits = 0;
    for (int b = 0; b < LANES; b++) hits += ((col & keys) >> b) & 1;
    mScore += hits;
    mRun = ((col & ~keys & 7) != 0) ? 0 : mRun + hits;
    if (mRun > mBestRun) mBestRun = mRun;
    mPos++;
  endtask

  // mode: 0 ready always high, 1 ready toggling 1/0, 2 random ready
  task automatic drawRun(input int mode, input int stepA, input int stepB);
    logic [19:0] expq[$];
    int k, cyc, idx, bitv, x, y;
    bit r;
    for (int ln = 0; ln < LANES; ln++)
      for (int s = VIS - 1; s >= 0; s--)
        for (int yy = 0; yy < BOX_H; yy++)
          for (int xx = 0; xx < BOX_W; xx++) begin
            idx  = mPos + s;
            bitv = (idx < songLen) ? ((song[idx] >> ln) & 1) : 0;
            x = X0 + (VIS - 1 - s) * BOX_W + xx;
            y = Y0 + ln * BOX_H + yy;
            expq.push_back({9'(x), 8'(y), (bitv != 0) ? 3'b101 : 3'b000});
          end
    k = 0;
    cyc = 0;
    while (k < expq.size() && cyc < 3000) begin
      step = (cyc == stepA) || (cyc == stepB);
      if (plot_valid) begin
        checkVal("pixel", 32'({plot_x, plot_y, plot_colour}), 32'(expq[k]));
        checkVal("pixel_sat", 32'({sPlotX, sPlotY, sPlotColour}), 32'(expq[k]));
        r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
        plot_ready = r;
        if (r) k++;
      end
      tick();
      cyc++;
    end
    step = 1'b0;
    plot_ready = 1'b1;
    if (k < expq.size()) checkVal("draw_timeout", k, expq.size());
    checkVal("plot_valid_fall", 32'(plot_valid), 0);
  endtask

  task automatic playSong(input int mode, input bit allowPend);
    int keys, guard;
    bit pend, dbl;
    guard = 0;
    while (guard < 2 * SONG_LEN + 2) begin
      guard++;
      pend = allowPend && (mPos < songLen) && 1'($urandom_range(0, 1));
      dbl  = pend && 1'($urandom_range(0, 1));
      keys = $urandom_range(0, 7);
      if (pend) note_in = 3'(keys);
      drawRun(mode, pend ? 4 : -1, dbl ? 7 : -1);
      if (dbl) mOver = 1;
      if (mPos == songLen) begin
        checkVal("song_done", 32'(song_done), 1);
        checkScores("end");
        return;
      end
      checkVal("not_done", 32'(song_done), 0);
      if (pend) begin
        tick();
      end else begin
        repeat ($urandom_range(0, 2)) tick();
        step = 1'b1;
        note_in = 3'(keys);
        tick();
        step = 1'b0;
      end
      modelStep(keys);
      checkScores("step");
    end
    checkVal("play_guard", mPos, songLen);
  endtask

  initial begin
    int t4Keys [4] = '{1, 1, 0, 7};
    int t4Score [4] = '{1, 2, 2, 5};
    int t4Streak [4] = '{1, 0, 0, 3};
    int t4Best [4] = '{1, 1, 1, 3};

    // T1: reset values, load to full, ignored fifth column
    doReset();
    reset = 1'b1;
    tick();
    checkCleared("reset");
    reset = 1'b0;
    song = '{1, 2, 4, 0};
    loadCols(4);
    checkVal("full_ready", 32'(col_ready), 0);
    col_valid = 1'b1; col_data = 3'b111;
    tick();
    col_valid = 1'b0;
    checkVal("full_ready2", 32'(col_ready), 0);

    // T2 draw, then random play of this song; DONE ignores step, start replays
    doStart(1'b0);
    checkVal("pv_latency", 32'(plot_valid), 0);
    playSong(0, 1'b0);
    step = 1'b1; note_in = 3'b111;
    tick();
    step = 1'b0;
    checkVal("done_hold", 32'(song_done), 1);
    checkScores("done_step");
    doStart(1'b0);
    playSong(1, 1'b1);

    // T4 scoring, directed
    doReset();
    song = '{1, 3, 0, 7};
    loadCols(4);
    doStart(1'b0);
    drawRun(0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      step = 1'b1; note_in = 3'(t4Keys[i]);
      tick();
      step = 1'b0;
      modelStep(t4Keys[i]);
      checkVal("t4_score", 32'(score), t4Score[i]);
      checkVal("t4_streak", 32'(streak), t4Streak[i]);
      checkVal("t4_best", 32'(best_streak), t4Best[i]);
      checkScores("t4");
      drawRun(2, -1, -1);
    end
    checkVal("t4_done", 32'(song_done), 1);

    // T5 saturation and overrun
    doReset();
    song = '{7, 7, 7, 7};
    loadCols(4);
    doStart(1'b0);
    note_in = 3'b111;
    drawRun(0, 5, 9);
    checkVal("t5_overrun", 32'(overrun), 1);
    mOver = 1;
    tick();
    modelStep(7);
    checkScores("t5a");
    drawRun(0, -1, -1);
    step = 1'b1;
    tick();
    step = 1'b0;
    modelStep(7);
    checkVal("t5_sat_score", 32'(sScore), 3);
    checkScores("t5b");
    playSong(2, 1'b1);

    // Random songs; some starts collide with a col_valid that must be ignored
    for (int trial = 0; trial < 8; trial++) begin
      int n;
      doReset();
      n = $urandom_range(1, SONG_LEN);
      for (int i = 0; i < SONG_LEN; i++) song[i] = $urandom_range(0, 7);
      loadCols(n);
      doStart(1'($urandom_range(0, 1)));
      playSong($urandom_range(0, 2), 1'b1);
    end

    // T6 reset mid-draw, then start with an empty song
    doReset();
    song = '{5, 2, 0, 0};
    loadCols(2);
    doStart(1'b0);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    checkCleared("mid_reset");
    reset = 1'b0;
    songLen = 0;
    doStart(1'b0);
    checkVal("empty_done", 32'(song_done), 1);
    checkVal("empty_score", 32'(score), 0);
    checkVal("empty_valid", 32'(plot_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
